// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM states, NOP encoding and fetch-queue entry layout.
package ifu_pkg;
    // pc field is sized for the widest supported XLEN; narrower cores use the low bits
    localparam int PC_W = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [2:0] {IDLE, XLATE, REQ, WAIT, DROP, HALT} state_t;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic            page_fault;
        logic            misaligned;
    } entry_t;
endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: circular buffer of fetched entries; flush empties it in one cycle.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    entry_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign do_push = push && !flush && count != CW'(DEPTH);
    assign do_pop = pop && !flush && count != '0;
    assign head = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= wptr + AW'(do_push);
            rptr <= rptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: one-at-a-time instruction fetch with optional MMU translation,
// buffering fetched instructions (or trap markers) for decode.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h3000_0000)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    input  logic                   mmu_enable_i,
    output logic                   mmu_req_valid_o,
    output logic [XLEN-1:0]        mmu_req_vaddr_o,
    input  logic                   mmu_resp_valid_i,
    input  logic [XLEN-1:0]        mmu_resp_paddr_i,
    input  logic                   mmu_page_fault_i,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [XLEN-1:0]        mem_req_addr_o,
    input  logic                   mem_rvalid_i,
    input  logic [31:0]            mem_rdata_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        out_pc_o,
    output logic [31:0]            out_inst_o,
    output logic                   out_page_fault_o,
    output logic                   out_misaligned_o,
    output logic                   ram_stall_valid_if_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t state;
    logic [XLEN-1:0] fetch_pc;
    logic start, push_mis, push_pf, push_rd, push, resp_any;
    entry_t push_data, head;
    assign start = state == IDLE && count_o < CW'(DEPTH);
    assign push_mis = start && fetch_pc[1:0] != 2'b00;
    assign push_pf = state == XLATE && mmu_resp_valid_i && mmu_page_fault_i;
    assign push_rd = state == WAIT && mem_rvalid_i;
    assign push = (push_mis || push_pf || push_rd) && !redirect_valid_i;
    assign resp_any = mmu_resp_valid_i || mem_rvalid_i;
    assign push_data = '{pc: PC_W'(fetch_pc), inst: push_rd ? mem_rdata_i : NOP,
                         page_fault: push_pf, misaligned: push_mis};

    ifu_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid_i),
        .push      (push),
        .push_data (push_data),
        .pop       (out_valid_o && out_ready_i),
        .head      (head),
        .count     (count_o)
    );

    assign out_valid_o = count_o != '0;
    assign ram_stall_valid_if_o = !out_valid_o;
    assign out_pc_o = out_valid_o ? head.pc[XLEN-1:0] : '0;
    assign out_inst_o = out_valid_o ? head.inst : '0;
    assign out_page_fault_o = out_valid_o && head.page_fault;
    assign out_misaligned_o = out_valid_o && head.misaligned;

    if (XLEN < PC_W) begin : g_pc_hi
        logic unused_pc_hi;
        assign unused_pc_hi = |head.pc[PC_W-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            mmu_req_valid_o <= 1'b0;
            mmu_req_vaddr_o <= '0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o <= '0;
        end else if (redirect_valid_i) begin
            fetch_pc <= redirect_pc_i;
            mmu_req_valid_o <= 1'b0;
            mem_req_valid_o <= 1'b0;
            // a response landing in the redirect cycle is already consumed, so no DROP
            state <= (state == XLATE && !mmu_resp_valid_i) || (state == WAIT && !mem_rvalid_i) ||
                     (state == REQ && mem_req_ready_i) || (state == DROP && !resp_any) ? DROP : IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (fetch_pc[1:0] != 2'b00) state <= HALT;
                    else if (mmu_enable_i) begin
                        state <= XLATE;
                        mmu_req_valid_o <= 1'b1;
                        mmu_req_vaddr_o <= fetch_pc;
                    end else begin
                        state <= REQ;
                        mem_req_valid_o <= 1'b1;
                        mem_req_addr_o <= fetch_pc;
                    end
                end
                XLATE: if (mmu_resp_valid_i) begin
                    mmu_req_valid_o <= 1'b0;
                    if (mmu_page_fault_i) state <= HALT;
                    else begin
                        state <= REQ;
                        mem_req_valid_o <= 1'b1;
                        mem_req_addr_o <= mmu_resp_paddr_i;
                    end
                end
                REQ: if (mem_req_ready_i) begin
                    mem_req_valid_o <= 1'b0;
                    state <= WAIT;
                end
                WAIT: if (mem_rvalid_i) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                    state <= IDLE;
                end
                DROP: if (resp_any) state <= IDLE;
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ifu_fetch_queue.sv
// tb_ifu_fetch_queue: bench acting as MMU and memory; every popped entry is compared
// with an in-order fetch stream restarted at each redirect.
module tb_ifu_fetch_queue;
    localparam logic [31:0] MMU_OFF = 32'h5000_0000;
    localparam logic [31:0] NOP_I = 32'h0000_0013;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;
    logic        redirect_valid_i = 1'b0, mmu_enable_i = 1'b0;
    logic [31:0] redirect_pc_i = '0, mmu_resp_paddr_i = '0, mem_rdata_i = '0;
    logic        mmu_resp_valid_i = 1'b0, mmu_page_fault_i = 1'b0;
    logic        mem_req_ready_i = 1'b0, mem_rvalid_i = 1'b0, out_ready_i = 1'b0;
    logic        mmu_req_valid_o, mem_req_valid_o, out_valid_o;
    logic [31:0] mmu_req_vaddr_o, mem_req_addr_o, out_pc_o, out_inst_o;
    logic        out_page_fault_o, out_misaligned_o, ram_stall_valid_if_o;
    logic [2:0]  count_o;

    ifu_fetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .mmu_enable_i(mmu_enable_i), .mmu_req_valid_o(mmu_req_valid_o),
        .mmu_req_vaddr_o(mmu_req_vaddr_o), .mmu_resp_valid_i(mmu_resp_valid_i),
        .mmu_resp_paddr_i(mmu_resp_paddr_i), .mmu_page_fault_i(mmu_page_fault_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_page_fault_o(out_page_fault_o),
        .out_misaligned_o(out_misaligned_o), .ram_stall_valid_if_o(ram_stall_valid_if_o),
        .count_o(count_o)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // environment knobs, written by the main sequence at negedges
    int          out_mode = 0, lat_fix = 0;
    bit          rnd_mem = 0, rnd_redir = 0, man_redir = 0, man_mmu = 0;
    logic [31:0] man_pc = '0, fault_va = 32'h1;
    // reference stream
    logic [31:0] m_pc = 32'h3000_0000, last_inst = '0;
    bit          m_mmu = 0, m_halt = 0, last_pf = 0, last_mis = 0;
    logic [31:0] pop_log[$];
    int          pops = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction
    function automatic bit faults(input logic [31:0] v);
        return v == fault_va || v[7:2] == 6'h3f;
    endfunction
    function automatic int lat();
        return lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 3));
    endfunction

    initial begin : drv
        bit mmu_pend, mem_pend, e_mis, e_pf;
        int mmu_cnt, mem_cnt;
        logic [31:0] mmu_va, mem_pa, rpc, e_inst;
        mmu_pend = 0; mem_pend = 0; mmu_cnt = 0; mem_cnt = 0; mmu_va = '0; mem_pa = '0;
        forever begin
            @(posedge clk); #1;
            mmu_resp_valid_i = 0; mmu_page_fault_i = 0; mem_rvalid_i = 0; redirect_valid_i = 0;
            if (!mmu_pend && mmu_req_valid_o) begin
                mmu_pend = 1; mmu_cnt = lat(); mmu_va = mmu_req_vaddr_o;
            end
            if (mmu_pend) begin
                if (mmu_cnt == 0) begin
                    mmu_pend = 0; mmu_resp_valid_i = 1;
                    mmu_resp_paddr_i = mmu_va + MMU_OFF; mmu_page_fault_i = faults(mmu_va);
                end else mmu_cnt--;
            end
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    mem_pend = 0; mem_rvalid_i = 1; mem_rdata_i = mdata(mem_pa);
                end else mem_cnt--;
            end
            mem_req_ready_i = rnd_mem ? $urandom_range(0, 2) != 0 : 1'b1;
            if (mem_req_valid_o && mem_req_ready_i) begin
                mem_pend = 1; mem_cnt = lat(); mem_pa = mem_req_addr_o;
            end
            out_ready_i = out_mode == 2 ? $urandom_range(0, 3) != 0 : out_mode == 1;
            if (man_redir || (rnd_redir && $urandom_range(0, 39) == 0)) begin
                rpc = $urandom;
                if ($urandom_range(0, 9) != 0) rpc[1:0] = 2'b00;
                redirect_valid_i = 1;
                redirect_pc_i = man_redir ? man_pc : rpc;
                mmu_enable_i = man_redir ? man_mmu : 1'($urandom_range(0, 1));
                man_redir = 0;
                m_pc = redirect_pc_i; m_mmu = mmu_enable_i; m_halt = 0;
                pop_log.delete();
            end else if (out_valid_o && out_ready_i) begin
                pops++;
                if (m_halt) chk("pop_after_trap", 1, 0);
                else begin
                    e_mis = m_pc[1:0] != 2'b00;
                    e_pf = !e_mis && m_mmu && faults(m_pc);
                    e_inst = (e_mis || e_pf) ? NOP_I : mdata(m_mmu ? m_pc + MMU_OFF : m_pc);
                    chk("out_pc", out_pc_o, m_pc);
                    chk("out_inst", out_inst_o, e_inst);
                    chk("out_pf", out_page_fault_o, e_pf);
                    chk("out_mis", out_misaligned_o, e_mis);
                    pop_log.push_back(out_pc_o);
                    last_pf = out_page_fault_o; last_mis = out_misaligned_o; last_inst = out_inst_o;
                    if (e_mis || e_pf) m_halt = 1;
                    else m_pc += 32'd4;
                end
            end
        end
    end

    task automatic redirect_to(input logic [31:0] pc, input bit mmu);
        man_pc = pc; man_mmu = mmu; man_redir = 1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : seq
        bit ok;
        int base;
        repeat (3) @(negedge clk);
        chk("rst_count", count_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_stall", ram_stall_valid_if_o, 1);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_mmu_valid", mmu_req_valid_o, 0);
        chk("rst_out_pc", out_pc_o, 0);
        chk("rst_mem_addr", mem_req_addr_o, 0);
        out_mode = 1;
        rst_n = 1;
        repeat (30) @(negedge clk);
        chk("seq_pc0", pop_log[0], 32'h3000_0000);
        chk("seq_pc1", pop_log[1], 32'h3000_0004);
        chk("seq_pc2", pop_log[2], 32'h3000_0008);
        out_mode = 0;
        redirect_to(32'h3000_0000, 0);
        repeat (30) @(negedge clk);
        chk("full_count", count_o, 4);
        chk("full_stall", ram_stall_valid_if_o, 0);
        for (int i = 0; i < 4; i++) begin
            chk("full_no_req", mem_req_valid_o, 0);
            @(negedge clk);
        end
        out_mode = 1;
        repeat (20) @(negedge clk);
        chk("full_pc0", pop_log[0], 32'h3000_0000);
        chk("fifth_pc", pop_log[4], 32'h3000_0010);
        redirect_to(32'h3000_0000, 1);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = mem_req_valid_o;
        end
        chk("xlate_req_seen", ok, 1);
        chk("xlate_addr", mem_req_addr_o, 32'h8000_0000);
        repeat (20) @(negedge clk);
        chk("xlate_pc0", pop_log[0], 32'h3000_0000);
        fault_va = 32'h3000_0004;
        redirect_to(32'h3000_0000, 1);
        repeat (30) @(negedge clk);
        chk("pf_pops", pop_log.size(), 2);
        chk("pf_pc", pop_log[1], 32'h3000_0004);
        chk("pf_flag", last_pf, 1);
        chk("pf_inst", last_inst, NOP_I);
        for (int i = 0; i < 5; i++) begin
            chk("halt_quiet", {mem_req_valid_o, mmu_req_valid_o}, 0);
            @(negedge clk);
        end
        fault_va = 32'h1;
        redirect_to(32'h3000_0100, 1);
        repeat (20) @(negedge clk);
        chk("resume_pc", pop_log[0], 32'h3000_0100);
        lat_fix = 2;
        redirect_to(32'h3000_0000, 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = mem_req_valid_o && mem_req_ready_i;
        end
        chk("drop_hs_seen", ok, 1);
        redirect_to(32'h3000_0040, 0);
        repeat (20) @(negedge clk);
        chk("drop_next_pc", pop_log[0], 32'h3000_0040);
        redirect_to(32'h3000_0042, 0);
        repeat (10) @(negedge clk);
        chk("mis_pops", pop_log.size(), 1);
        chk("mis_pc", pop_log[0], 32'h3000_0042);
        chk("mis_flag", last_mis, 1);
        lat_fix = 0;
        redirect_to(32'hFFFF_FFF8, 0);
        repeat (20) @(negedge clk);
        chk("wrap_pc", pop_log[2], 32'h0000_0000);
        base = pops;
        lat_fix = -1; rnd_mem = 1; out_mode = 2; rnd_redir = 1;
        repeat (3000) @(negedge clk);
        rnd_redir = 0;
        chk("rand_liveness", pops - base > 200, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
